// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment
// patterns (bit7..bit0 = a,b,c,d,e,f,g,dp) and segment bit positions.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'hFE;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_0 = 8'b0000_0011;
  localparam logic [7:0] SEG_1 = 8'b1001_1111;
  localparam logic [7:0] SEG_2 = 8'b0010_0101;
  localparam logic [7:0] SEG_3 = 8'b0000_1101;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b0100_1001;
  localparam logic [7:0] SEG_6 = 8'b0100_0001;
  localparam logic [7:0] SEG_7 = 8'b0001_1111;
  localparam logic [7:0] SEG_8 = 8'b0000_0001;
  localparam logic [7:0] SEG_9 = 8'b0000_1001;

  localparam logic [7:0] SEG_HA = 8'b0001_0001;
  localparam logic [7:0] SEG_HB = 8'b1100_0001;
  localparam logic [7:0] SEG_HC = 8'b0110_0011;
  localparam logic [7:0] SEG_HD = 8'b1000_0101;
  localparam logic [7:0] SEG_HE = 8'b0110_0001;
  localparam logic [7:0] SEG_HF = 8'b0111_0001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit code + dp + blank -> active-low
// segment pattern. Define SEG7_HEX_EN to show codes 10-15 as A,b,C,d,E,F;
// otherwise they render dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_n_o
);

  logic [7:0] pat;

  // Glyph lookup; a blanked digit keeps only its dp so a lone point can still show.
  always_comb begin
    pat = SEG_OFF;
    if (!blank_i) begin
      case (code_i)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
`ifdef SEG7_HEX_EN
        4'd10:   pat = SEG_HA;
        4'd11:   pat = SEG_HB;
        4'd12:   pat = SEG_HC;
        4'd13:   pat = SEG_HD;
        4'd14:   pat = SEG_HE;
        4'd15:   pat = SEG_HF;
`endif
        default: pat = SEG_OFF;
      endcase
    end
    if (dp_i) pat[SEG_DP] = 1'b0;
    seg_n_o = pat;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver. Takes a frame
// snapshot of bcd_in/dp_in once per full scan, blanks leading zeros on the
// snapshot, and keeps all anodes off for GUARD_CYCLES at each slot start.
// Optional macro: SEG7_HEX_EN (hex glyphs for codes 10-15, see seg7_decode).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      snap_bcd_q, snap_bcd_d;
  logic [NUM_DIGITS-1:0]           snap_dp_q, snap_dp_d;
  logic [7:0]                      seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]           an_n_q, an_n_d;
  logic                            frame_start_q, frame_start_d;

  logic                            slot_end, frame_end, an_on, lead;
  logic [NUM_DIGITS-1:0]           blank;
  logic [NUM_DIGITS-1:0][7:0]      dec;

  assign slot_end  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign an_on     = enable && (cnt_q >= CNT_W'(GUARD_CYCLES));

  // Leading-zero mask: walk down from the MSD until the first nonzero digit; digit 0 always shows.
  always_comb begin
    blank = '0;
    lead  = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (snap_bcd_q[i] != 4'd0) lead = 1'b0;
      blank[i] = lead;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .code_i  (snap_bcd_q[g]),
      .dp_i    (snap_dp_q[g]),
      .blank_i (blank[g]),
      .seg_n_o (dec[g])
    );
  end

  // Next state: slot counter, digit index, frame snapshot and registered outputs.
  always_comb begin
    cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    snap_bcd_d    = snap_bcd_q;
    snap_dp_d     = snap_dp_q;
    frame_start_d = frame_end;
    an_n_d        = '1;
    seg_n_d       = SEG_OFF;
    if (slot_end) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    if (frame_end) begin
      snap_bcd_d = bcd_in;
      snap_dp_d  = dp_in;
    end
    if (an_on) begin
      an_n_d[idx_q] = 1'b0;
      seg_n_d       = dec[idx_q];
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_bcd_q    <= '0;
      snap_dp_q     <= '0;
      seg_n_q       <= SEG_OFF;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_bcd_q    <= snap_bcd_d;
      snap_dp_q     <= snap_dp_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NUM_DIGITS=4, SLOT_CYCLES=8,
// GUARD_CYCLES=2). Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset, enable, lz_blank, frame_start;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in, an_n;
  logic [7:0]  seg_n;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] P0 = 8'b0000_0011, P1 = 8'b1001_1111, P2 = 8'b0010_0101;
  localparam logic [7:0] P3 = 8'b0000_1101, P4 = 8'b1001_1001, P7 = 8'b0001_1111;
  localparam logic [7:0] OFF = 8'hFF, DPO = 8'hFE;

  seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bcd_in(bcd_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg_n(seg_n), .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a frame_start cycle; checks the 32 cycles of the displayed frame
  // and loads the next snapshot inputs mid-frame (they must stay invisible).
  task automatic walk(input string nm, input logic [7:0] e3, input logic [7:0] e2,
                      input logic [7:0] e1, input logic [7:0] e0,
                      input logic [15:0] nb, input logic [3:0] nd);
    logic [7:0] e [4];
    logic [3:0] onehot;
    int d, ph;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int c = 1; c <= 32; c++) begin
      step();
      d  = (c - 1) / 8;
      ph = (c - 1) % 8;
      onehot = ~(4'b0001 << d);
      if (c == 16) begin
        bcd_in = nb;
        dp_in  = nd;
      end
      if (c == 1 || c == 16) chk($sformatf("%s_fs_low%0d", nm, c), 32'(frame_start), 32'd0);
      if (c == 32)           chk($sformatf("%s_fs_pulse", nm), 32'(frame_start), 32'd1);
      if (ph == 0) begin
        chk($sformatf("%s_d%0d_guard_an", nm, d), 32'(an_n), 32'hF);
        chk($sformatf("%s_d%0d_guard_seg", nm, d), 32'(seg_n), 32'(OFF));
      end
      if (ph == 2 || ph == 7) begin
        chk($sformatf("%s_d%0d_p%0d_an", nm, d, ph), 32'(an_n), 32'(onehot));
        chk($sformatf("%s_d%0d_p%0d_seg", nm, d, ph), 32'(seg_n), 32'(e[d]));
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1; lz_blank = 1'b0; bcd_in = 16'h0000; dp_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Cycles 0..2 dark, cycle 3 shows digit 0 of the all-zero snapshot.
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'(OFF));
    chk("rst_fs", 32'(frame_start), 32'd0);
    step(); step();
    chk("c2_an", 32'(an_n), 32'hF);
    chk("c2_seg", 32'(seg_n), 32'(OFF));
    step();
    chk("c3_an", 32'(an_n), 32'hE);
    chk("c3_seg", 32'(seg_n), 32'(P0));

    bcd_in = 16'h1234;
    n = 0;
    while (!frame_start && n < 64) begin
      step();
      n++;
    end
    chk("first_frame_cycle", 32'(3 + n), 32'd32);

    walk("f1234", P1, P2, P3, P4, 16'h0070, 4'b0000);
    lz_blank = 1'b1;
    walk("f0070_lz", OFF, OFF, P7, P0, 16'h0070, 4'b0000);
    lz_blank = 1'b0;
    walk("f0070_nolz", P0, P0, P7, P0, 16'h0000, 4'b0100);
    lz_blank = 1'b1;
    walk("f0000_dp2", OFF, DPO, OFF, P0, 16'h0000, 4'b0101);
    walk("f0000_dp20", OFF, DPO, OFF, P0 & 8'hFE, 16'h1111, 4'b0000);
    walk("f1111", P1, P1, P1, P1, 16'h2222, 4'b0000);
    walk("f2222", P2, P2, P2, P2, 16'hABCD, 4'b0000);
`ifdef SEG7_HEX_EN
    walk("fABCD", 8'b0001_0001, 8'b1100_0001, 8'b0110_0011, 8'b1000_0101, 16'hABCD, 4'b0000);
`else
    walk("fABCD", OFF, OFF, OFF, OFF, 16'hABCD, 4'b0000);
`endif

    // Now at a frame_start cycle; disable during digit 0, re-enable in digit 1's slot.
    step(); step(); step();
    chk("en_on_an", 32'(an_n), 32'hE);
    enable = 1'b0;
    step();
    chk("en_off_an", 32'(an_n), 32'hF);
    chk("en_off_seg", 32'(seg_n), 32'(OFF));
    repeat (7) step();
    chk("en_off_late_an", 32'(an_n), 32'hF);
    enable = 1'b1;
    step();
    chk("en_back_an", 32'(an_n), 32'hD);

    // Mid-slot reset: everything back to reset values on the next edge.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_an", 32'(an_n), 32'hF);
    chk("mrst_seg", 32'(seg_n), 32'(OFF));
    chk("mrst_fs", 32'(frame_start), 32'd0);
    step(); step(); step();
    chk("mrst_c3_an", 32'(an_n), 32'hE);
    chk("mrst_c3_seg", 32'(seg_n), 32'(P0));
    repeat (8) step();
    chk("mrst_d1_an", 32'(an_n), 32'hD);
    chk("mrst_d1_seg", 32'(seg_n), 32'(OFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
